pwm_dual_gen: RTL and testbench

Dual-channel PWM generator that consumes the pitch and yaw duty words produced by the SPI slave and drives the two motor PWM pins. Duty requests are sampled into shadow registers and applied only at a period boundary, so every PWM period is glitch-free. Requests at or above `MAX_COUNT` saturate to 100 % duty. Sits directly downstream of the SPI slave, in the same `clk` domain.

---
 rtl/pwm_dual_gen.sv | 111 +++++++++++
 tb/tb_pwm_dual_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pwm_dual_gen.sv
// Dual-channel PWM generator with period-boundary shadowed duty and request saturation.
// Optional per-period duty slew limiting is enabled by defining PWM_SLEW_LIMIT_EN.
module pwm_dual_gen #(
  parameter int unsigned MAX_COUNT = 512,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned SLEW_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pitch_pwm,
  input  logic [15:0] yaw_pwm,
  output logic        pitch_pwm_out,
  output logic        yaw_pwm_out,
  output logic        period_start,
  output logic        pitch_sat,
  output logic        yaw_sat
);

  localparam int unsigned    PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);
  localparam logic [15:0]    MaxCnt  = 16'(MAX_COUNT);
  localparam logic [15:0]    CntLast = 16'(MAX_COUNT - 1);
  localparam logic [15:0]    DutyRst = 16'(MAX_COUNT >> 1);
  localparam logic [16:0]    Step    = 17'(SLEW_STEP);

  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     pitch_duty_q, pitch_duty_d;
  logic [15:0]     yaw_duty_q, yaw_duty_d;
  logic            pitch_sat_q, pitch_sat_d;
  logic            yaw_sat_q, yaw_sat_d;
  logic            pitch_out_q, yaw_out_q;
  logic            period_start_q;
  logic            tick, period_end;
  logic [15:0]     pitch_req_c, yaw_req_c;

  // Move cur toward req by at most Step; differences are taken in 17 bits so they cannot wrap.
  function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] req);
    logic [16:0] diff;
    logic [16:0] res;
    res = {1'b0, req};
    if (req > cur) begin
      diff = {1'b0, req} - {1'b0, cur};
      if (diff > Step) res = {1'b0, cur} + Step;
    end else if (req < cur) begin
      diff = {1'b0, cur} - {1'b0, req};
      if (diff > Step) res = {1'b0, cur} - Step;
    end
    return res[15:0];
  endfunction

  assign tick        = (pre_cnt_q == PreLast);
  assign period_end  = tick && (cnt_q == CntLast);
  assign pitch_req_c = (pitch_pwm > MaxCnt) ? MaxCnt : pitch_pwm;
  assign yaw_req_c   = (yaw_pwm > MaxCnt) ? MaxCnt : yaw_pwm;

  always_comb begin
    pre_cnt_d    = tick ? '0 : pre_cnt_q + 1'b1;
    cnt_d        = cnt_q;
    pitch_duty_d = pitch_duty_q;
    yaw_duty_d   = yaw_duty_q;
    pitch_sat_d  = pitch_sat_q;
    yaw_sat_d    = yaw_sat_q;
    if (tick) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 16'd1;
    end
    if (period_end) begin
`ifdef PWM_SLEW_LIMIT_EN
      pitch_duty_d = slew(pitch_duty_q, pitch_req_c);
      yaw_duty_d   = slew(yaw_duty_q, yaw_req_c);
`else
      pitch_duty_d = pitch_req_c;
      yaw_duty_d   = yaw_req_c;
`endif
      pitch_sat_d  = (pitch_pwm > MaxCnt);
      yaw_sat_d    = (yaw_pwm > MaxCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      pitch_duty_q   <= DutyRst;
      yaw_duty_q     <= DutyRst;
      pitch_sat_q    <= 1'b0;
      yaw_sat_q      <= 1'b0;
      pitch_out_q    <= 1'b0;
      yaw_out_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      pitch_duty_q   <= pitch_duty_d;
      yaw_duty_q     <= yaw_duty_d;
      pitch_sat_q    <= pitch_sat_d;
      yaw_sat_q      <= yaw_sat_d;
      // Compare uses the current count and duty; output lags cnt by one clk.
      pitch_out_q    <= (cnt_q < pitch_duty_q);
      yaw_out_q      <= (cnt_q < yaw_duty_q);
      period_start_q <= period_end;
    end
  end

  assign pitch_pwm_out = pitch_out_q;
  assign yaw_pwm_out   = yaw_out_q;
  assign period_start  = period_start_q;
  assign pitch_sat     = pitch_sat_q;
  assign yaw_sat       = yaw_sat_q;

endmodule

// File: tb/tb_pwm_dual_gen.sv
// Randomized bench for pwm_dual_gen: three instances (8/1, 8/3, 512/1) checked every clk
// against a period-arithmetic reference model.
module tb_pwm_dual_gen;

  localparam int NDut = 3;
  localparam int Step = 8;
  localparam int MaxC [NDut] = '{8, 8, 512};
  localparam int Pre  [NDut] = '{1, 3, 1};

  logic        clk;
  logic        rst;
  logic [15:0] pitch_pwm, yaw_pwm;
  logic        po [NDut];
  logic        yo [NDut];
  logic        ps [NDut];
  logic        psat [NDut];
  logic        ysat [NDut];

  pwm_dual_gen #(.MAX_COUNT(8), .PRESCALE(1), .SLEW_STEP(Step)) u_p1 (
    .clk(clk), .rst(rst), .pitch_pwm(pitch_pwm), .yaw_pwm(yaw_pwm),
    .pitch_pwm_out(po[0]), .yaw_pwm_out(yo[0]), .period_start(ps[0]),
    .pitch_sat(psat[0]), .yaw_sat(ysat[0])
  );

  pwm_dual_gen #(.MAX_COUNT(8), .PRESCALE(3), .SLEW_STEP(Step)) u_p3 (
    .clk(clk), .rst(rst), .pitch_pwm(pitch_pwm), .yaw_pwm(yaw_pwm),
    .pitch_pwm_out(po[1]), .yaw_pwm_out(yo[1]), .period_start(ps[1]),
    .pitch_sat(psat[1]), .yaw_sat(ysat[1])
  );

  pwm_dual_gen #(.MAX_COUNT(512), .PRESCALE(1), .SLEW_STEP(Step)) u_big (
    .clk(clk), .rst(rst), .pitch_pwm(pitch_pwm), .yaw_pwm(yaw_pwm),
    .pitch_pwm_out(po[2]), .yaw_pwm_out(yo[2]), .period_start(ps[2]),
    .pitch_sat(psat[2]), .yaw_sat(ysat[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model state: clk count since reset release, applied duties, expected registered outputs.
  int m_n  [NDut];
  int m_pd [NDut];
  int m_yd [NDut];
  int e_po [NDut];
  int e_yo [NDut];
  int e_ps [NDut];
  int e_psat [NDut];
  int e_ysat [NDut];

  function automatic int apply_duty(input int cur, input int req, input int m);
    int rc;
    rc = (req > m) ? m : req;
`ifdef PWM_SLEW_LIMIT_EN
    if (rc > cur) return (cur + Step < rc) ? cur + Step : rc;
    if (rc < cur) return (cur - Step > rc) ? cur - Step : rc;
    return cur;
`else
    return rc;
`endif
  endfunction

  // One clk edge of the reference: cnt and period_end follow from elapsed clk count alone.
  task automatic model_step(input int k, input bit r, input int preq, input int yreq);
    int len, ph, cnt;
    if (r) begin
      m_n[k] = 0; m_pd[k] = MaxC[k] / 2; m_yd[k] = MaxC[k] / 2;
      e_po[k] = 0; e_yo[k] = 0; e_ps[k] = 0; e_psat[k] = 0; e_ysat[k] = 0;
      return;
    end
    len     = MaxC[k] * Pre[k];
    ph      = m_n[k] % len;
    cnt     = ph / Pre[k];
    e_po[k] = (cnt < m_pd[k]) ? 1 : 0;
    e_yo[k] = (cnt < m_yd[k]) ? 1 : 0;
    e_ps[k] = (ph == len - 1) ? 1 : 0;
    if (ph == len - 1) begin
      m_pd[k]   = apply_duty(m_pd[k], preq, MaxC[k]);
      m_yd[k]   = apply_duty(m_yd[k], yreq, MaxC[k]);
      e_psat[k] = (preq > MaxC[k]) ? 1 : 0;
      e_ysat[k] = (yreq > MaxC[k]) ? 1 : 0;
    end
    m_n[k]++;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 8))
      0: return 16'd0;
      1: return 16'd4;
      2: return 16'd6;
      3: return 16'd8;
      4: return 16'd9;
      5: return 16'd300;
      6: return 16'($urandom_range(510, 514));
      7: return 16'($urandom_range(0, 600));
      default: return 16'($urandom);
    endcase
  endfunction

  localparam int SlewStart = 12000;
  localparam int NCyc      = SlewStart + 512 * 32 + 100;

  initial begin
    rst       = 1'b1;
    pitch_pwm = 16'd4;
    yaw_pwm   = 16'd4;
    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int k = 0; k < NDut; k++) begin
          check_val($sformatf("d%0d c%0d pitch_out", k, cyc), int'(po[k]), e_po[k]);
          check_val($sformatf("d%0d c%0d yaw_out", k, cyc), int'(yo[k]), e_yo[k]);
          check_val($sformatf("d%0d c%0d period_start", k, cyc), int'(ps[k]), e_ps[k]);
          check_val($sformatf("d%0d c%0d pitch_sat", k, cyc), int'(psat[k]), e_psat[k]);
          check_val($sformatf("d%0d c%0d yaw_sat", k, cyc), int'(ysat[k]), e_ysat[k]);
        end
      end
      // Stimulus for the next edge: reset, default duty, random mix, then a slew run.
      if (cyc < 3) begin
        rst = 1'b1;
      end else if (cyc < 200) begin
        rst = 1'b0;
      end else if (cyc < SlewStart) begin
        rst = ($urandom_range(0, 2499) == 0);
        if ($urandom_range(0, 39) == 0) pitch_pwm = pick();
        if ($urandom_range(0, 39) == 0) yaw_pwm = pick();
      end else if (cyc == SlewStart) begin
        rst       = 1'b1;
        pitch_pwm = 16'd20;
        yaw_pwm   = 16'd300;
      end else begin
        rst = 1'b0;
      end
      for (int k = 0; k < NDut; k++) begin
        model_step(k, rst, int'(pitch_pwm), int'(yaw_pwm));
      end
    end
    // The 512-tick channel must have settled at the small request by now, slewed or not.
    check_val("slew_final_duty", m_pd[2], 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
